fifo_drain_rd: RTL and testbench

- Read-side engine for the team's 16-bit synchronous FIFOs: it is the consumer end of the readp/emptyp/dout interface.
- Issues pops to the FIFO and absorbs its one-cycle registered read latency in a 2-entry skid buffer.
- Presents words downstream as a valid/ready stream at full throughput, with an enable/drain control FSM and a delivered-word counter.
- Sits between a fifo instance and any stream consumer (serializer, bus master).

---
 rtl/fifo_pkg.sv | 14 +
 rtl/fifo_skid2.sv | 76 +++++++
 rtl/fifo_drain_rd.sv | 108 ++++++++++
 tb/tb_fifo_drain_rd.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side drain engine: data width default,
// drain FSM encoding and skid-buffer depth.
package fifo_pkg;

    localparam int FIFO_DW    = 16;
    localparam int SKID_DEPTH = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } drain_state_e;

endpackage

// File: rtl/fifo_skid2.sv
// Two-entry skid buffer with registered head output; absorbs the FIFO read
// latency so the downstream stream can run at one word per cycle.
module fifo_skid2
    import fifo_pkg::*;
#(
    parameter int DW = FIFO_DW
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [1:0]    occ,
    output logic [DW-1:0] head
);

    logic [DW-1:0] head_q, head_d;
    logic [DW-1:0] tail_q, tail_d;
    logic [1:0]    occ_q, occ_d;
    logic          pop_ok;
    logic          push_ok;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        occ_d   = occ_q;
        pop_ok  = pop & (occ_q != 2'd0);
        push_ok = push & ((occ_q != 2'd2) | pop_ok);

        case (occ_q)
            2'd0: begin
                if (push_ok) begin
                    head_d = push_data;
                    occ_d  = 2'd1;
                end
            end
            2'd1: begin
                // Pop and push together: the new word replaces the departing head.
                if (push_ok && pop_ok) begin
                    head_d = push_data;
                end else if (push_ok) begin
                    tail_d = push_data;
                    occ_d  = 2'd2;
                end else if (pop_ok) begin
                    occ_d  = 2'd0;
                end
            end
            default: begin
                if (pop_ok) begin
                    head_d = tail_q;
                    if (push_ok) begin
                        tail_d = push_data;
                    end else begin
                        occ_d  = 2'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign occ  = occ_q;
    assign head = head_q;

endmodule

// File: rtl/fifo_drain_rd.sv
// Consumer end of a 16-bit synchronous FIFO: issues pops, tracks the in-flight
// read, and streams words out through a skid buffer with enable/drain control.
module fifo_drain_rd
    import fifo_pkg::*;
#(
    parameter int DW        = FIFO_DW,
    parameter int CNT_W     = 16,
    parameter int BUF_DEPTH = SKID_DEPTH
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             fifo_emptyp,
    input  logic [DW-1:0]    fifo_dout,
    output logic             fifo_readp,
    output logic             m_valid,
    output logic [DW-1:0]    m_data,
    input  logic             m_ready,
    output logic             busy,
    output logic [CNT_W-1:0] word_cnt
);

    localparam logic [2:0] DEPTH = 3'(BUF_DEPTH);

    drain_state_e     state_q, state_d;
    logic             inflight_q, inflight_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0]       occ;
    logic [DW-1:0]    head;
    logic             hs;
    logic [2:0]       credit_used;
    logic [2:0]       credit_cap;
    logic             drain_done;

    fifo_skid2 #(
        .DW (DW)
    ) u_skid (
        .clk       (clk),
        .rstn      (rstn),
        .push      (inflight_q),
        .push_data (fifo_dout),
        .pop       (hs),
        .occ       (occ),
        .head      (head)
    );

    assign m_valid = (occ != 2'd0);
    assign m_data  = head;
    assign hs      = m_valid & m_ready;

    // The word leaving this cycle frees a slot, so a full-rate stream never bubbles.
    assign credit_used = {1'b0, occ} + {2'b00, inflight_q};
    assign credit_cap  = DEPTH + {2'b00, hs};

    // Done when nothing is in flight and the buffer is empty after this cycle.
    assign drain_done = ~inflight_q & ((occ == 2'd0) | ((occ == 2'd1) & hs));

    always_comb begin
        state_d    = state_q;
        fifo_readp = 1'b0;
        busy       = 1'b1;

        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (en) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                fifo_readp = ~fifo_emptyp & (credit_used < credit_cap);
                if (!en) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (en) begin
                    state_d = ST_RUN;
                end else if (drain_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy    = 1'b0;
            end
        endcase

        inflight_d = fifo_readp;
        cnt_d      = cnt_q + CNT_W'(hs);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            inflight_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            cnt_q      <= cnt_d;
        end
    end

    assign word_cnt = cnt_q;

endmodule

// File: tb/tb_fifo_drain_rd.sv
// Directed bench for fifo_drain_rd with a registered-read FIFO model in front.
module tb_fifo_drain_rd;

    logic        clk = 1'b0;
    logic        rstn;
    logic        en;
    logic        fifo_emptyp;
    logic [15:0] fifo_dout = 16'h0;
    logic        fifo_readp;
    logic        m_valid;
    logic [15:0] m_data;
    logic        m_ready;
    logic        busy;
    logic [15:0] word_cnt;

    int checks = 0;
    int errors = 0;

    // FIFO model: a preloaded table plus a counting generator for long runs
    logic [15:0] fmem [0:63];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    int          gen_total = 0;
    int          gen_done = 0;
    logic [15:0] gen_val = 16'h0;
    int          pop_total = 0;
    int          viol = 0;

    logic [15:0] got [0:15];
    int          got_n;
    int          p0;
    int          cyc;

    assign fifo_emptyp = (gen_done == gen_total) && (rd_ptr == wr_ptr);

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fifo_readp && fifo_emptyp) viol <= viol + 1;
        if (fifo_readp && !fifo_emptyp) begin
            pop_total <= pop_total + 1;
            if (gen_done != gen_total) begin
                fifo_dout <= gen_val;
                gen_val   <= gen_val + 16'h1;
                gen_done  <= gen_done + 1;
            end else begin
                fifo_dout <= fmem[rd_ptr];
                rd_ptr    <= rd_ptr + 1;
            end
        end
    end

    fifo_drain_rd #(
        .DW        (16),
        .CNT_W     (16),
        .BUF_DEPTH (2)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .en          (en),
        .fifo_emptyp (fifo_emptyp),
        .fifo_dout   (fifo_dout),
        .fifo_readp  (fifo_readp),
        .m_valid     (m_valid),
        .m_data      (m_data),
        .m_ready     (m_ready),
        .busy        (busy),
        .word_cnt    (word_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] v);
        fmem[wr_ptr] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic do_reset();
        en = 1'b0;
        m_ready = 1'b0;
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic collect(input int n, input int budget);
        got_n = 0;
        for (int c = 0; c < budget && got_n < n; c++) begin
            if (m_valid && m_ready) begin
                got[got_n] = m_data;
                got_n = got_n + 1;
            end
            tick();
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int c = 0; c < budget && busy; c++) tick();
        chk(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        rstn = 1'b0;
        en = 1'b0;
        m_ready = 1'b0;
        tick();
        tick();
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_readp", 32'(fifo_readp), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cnt", 32'(word_cnt), 32'd0);
        rstn = 1'b1;
        tick();

        // 1: three words at full rate
        push(16'h1111); push(16'h2222); push(16'h3333);
        m_ready = 1'b1;
        en = 1'b1;
        tick();
        chk("t1_e1_readp", 32'(fifo_readp), 32'd1);
        chk("t1_e1_busy", 32'(busy), 32'd1);
        chk("t1_e1_valid", 32'(m_valid), 32'd0);
        tick();
        chk("t1_e2_readp", 32'(fifo_readp), 32'd1);
        chk("t1_e2_valid", 32'(m_valid), 32'd0);
        tick();
        chk("t1_e3_readp", 32'(fifo_readp), 32'd1);
        chk("t1_e3_valid", 32'(m_valid), 32'd1);
        chk("t1_e3_data", 32'(m_data), 32'h1111);
        tick();
        chk("t1_e4_readp", 32'(fifo_readp), 32'd0);
        chk("t1_e4_data", 32'(m_data), 32'h2222);
        chk("t1_e4_cnt", 32'(word_cnt), 32'd1);
        tick();
        chk("t1_e5_valid", 32'(m_valid), 32'd1);
        chk("t1_e5_data", 32'(m_data), 32'h3333);
        tick();
        chk("t1_e6_valid", 32'(m_valid), 32'd0);
        chk("t1_e6_cnt", 32'(word_cnt), 32'd3);
        chk("t1_e6_data_hold", 32'(m_data), 32'h3333);
        tick(); tick(); tick();
        chk("t1_busy_empty", 32'(busy), 32'd1);
        chk("t1_readp_empty", 32'(fifo_readp), 32'd0);
        en = 1'b0;
        wait_idle("t1_idle", 10);

        // 2: backpressure limits pops to the skid depth
        do_reset();
        push(16'hA001); push(16'hA002); push(16'hA003); push(16'hA004);
        p0 = pop_total;
        en = 1'b1;
        tick();
        chk("t2_e1_readp", 32'(fifo_readp), 32'd1);
        tick();
        chk("t2_e2_readp", 32'(fifo_readp), 32'd1);
        tick();
        chk("t2_e3_readp", 32'(fifo_readp), 32'd0);
        chk("t2_e3_valid", 32'(m_valid), 32'd1);
        chk("t2_e3_data", 32'(m_data), 32'hA001);
        tick(); tick();
        chk("t2_hold_readp", 32'(fifo_readp), 32'd0);
        chk("t2_hold_data", 32'(m_data), 32'hA001);
        chk("t2_pops", 32'(pop_total - p0), 32'd2);
        m_ready = 1'b1;
        collect(4, 20);
        chk("t2_got_n", 32'(got_n), 32'd4);
        chk("t2_w0", 32'(got[0]), 32'hA001);
        chk("t2_w1", 32'(got[1]), 32'hA002);
        chk("t2_w2", 32'(got[2]), 32'hA003);
        chk("t2_w3", 32'(got[3]), 32'hA004);
        chk("t2_cnt", 32'(word_cnt), 32'd4);
        en = 1'b0;
        wait_idle("t2_idle", 10);

        // 3: en drops in the cycle a pop issues
        do_reset();
        push(16'hB001); push(16'hB002); push(16'hB003);
        p0 = pop_total;
        m_ready = 1'b1;
        en = 1'b1;
        tick();
        chk("t3_e1_readp", 32'(fifo_readp), 32'd1);
        en = 1'b0;
        tick();
        chk("t3_e2_readp", 32'(fifo_readp), 32'd0);
        chk("t3_e2_busy", 32'(busy), 32'd1);
        tick();
        chk("t3_e3_valid", 32'(m_valid), 32'd1);
        chk("t3_e3_data", 32'(m_data), 32'hB001);
        chk("t3_e3_readp", 32'(fifo_readp), 32'd0);
        tick();
        chk("t3_e4_busy", 32'(busy), 32'd0);
        chk("t3_e4_valid", 32'(m_valid), 32'd0);
        chk("t3_e4_cnt", 32'(word_cnt), 32'd1);
        chk("t3_pops", 32'(pop_total - p0), 32'd1);
        en = 1'b1;
        collect(2, 20);
        chk("t3_got_n", 32'(got_n), 32'd2);
        chk("t3_w1", 32'(got[0]), 32'hB002);
        chk("t3_w2", 32'(got[1]), 32'hB003);
        en = 1'b0;
        wait_idle("t3_idle", 10);
        chk("t3_cnt", 32'(word_cnt), 32'd3);

        // 4: FIFO empty throughout
        do_reset();
        m_ready = 1'b1;
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t4_readp", 32'(fifo_readp), 32'd0);
            chk("t4_valid", 32'(m_valid), 32'd0);
        end
        chk("t4_cnt", 32'(word_cnt), 32'd0);
        chk("t4_busy", 32'(busy), 32'd1);

        // 5: asynchronous reset with the skid buffer full
        push(16'hC001);
        collect(1, 10);
        chk("t5_pre_w", 32'(got[0]), 32'hC001);
        chk("t5_pre_cnt", 32'(word_cnt), 32'd1);
        m_ready = 1'b0;
        p0 = pop_total;
        push(16'hC002); push(16'hC003); push(16'hC004); push(16'hC005); push(16'hC006);
        for (int i = 0; i < 5; i++) tick();
        chk("t5_full_valid", 32'(m_valid), 32'd1);
        chk("t5_full_data", 32'(m_data), 32'hC002);
        chk("t5_full_readp", 32'(fifo_readp), 32'd0);
        chk("t5_full_pops", 32'(pop_total - p0), 32'd2);
        #2;
        rstn = 1'b0;
        #1;
        chk("t5_async_valid", 32'(m_valid), 32'd0);
        chk("t5_async_readp", 32'(fifo_readp), 32'd0);
        chk("t5_async_cnt", 32'(word_cnt), 32'd0);
        chk("t5_async_busy", 32'(busy), 32'd0);
        chk("t5_async_data", 32'(m_data), 32'd0);
        tick();
        rstn = 1'b1;
        m_ready = 1'b1;
        collect(3, 20);
        chk("t5_got_n", 32'(got_n), 32'd3);
        chk("t5_w0", 32'(got[0]), 32'hC004);
        chk("t5_w1", 32'(got[1]), 32'hC005);
        chk("t5_w2", 32'(got[2]), 32'hC006);
        en = 1'b0;
        wait_idle("t5_idle", 10);

        // 6: 65536 deliveries wrap the counter
        do_reset();
        m_ready = 1'b1;
        en = 1'b1;
        gen_total = gen_done + 65536;
        cyc = 0;
        while ((gen_done != gen_total || m_valid) && cyc < 70000) begin
            tick();
            cyc++;
        end
        tick(); tick(); tick();
        chk("t6_timeout", 32'(cyc < 70000), 32'd1);
        chk("t6_rate", 32'(cyc <= 65536 + 6), 32'd1);
        chk("t6_wrap_cnt", 32'(word_cnt), 32'd0);
        chk("t6_last_data", 32'(m_data), 32'hFFFF);
        gen_total = gen_total + 1;
        for (int i = 0; i < 6; i++) tick();
        chk("t6_post_cnt", 32'(word_cnt), 32'd1);
        chk("t6_post_data", 32'(m_data), 32'h0000);
        en = 1'b0;
        wait_idle("t6_idle", 10);

        chk("pop_while_empty", 32'(viol), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
